nes_joypad: RTL and testbench

NES_JOYPAD -- requirements
Module: nes_joypad

---
 rtl/nes_joypad.sv | 136 +++++++++++++
 tb/tb_nes_joypad.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad.sv
// nes_joypad: two-port NES controller serializer with per-button synchronizer and debounce.
// Optional A/B turbo is built only when JOYPAD_TURBO_EN is defined.
module nes_joypad #(
  parameter int unsigned DEBOUNCE_CYCLES = 17897,
  parameter int unsigned TURBO_FRAMES    = 2
) (
  input  logic       clk_cpu,
  input  logic       rst_cpun,
  input  logic [7:0] btn_p1,
  input  logic [7:0] btn_p2,
  input  logic [1:0] pad_present,
  input  logic [3:0] turbo,
  input  logic       vblank,
  input  logic       ctrl_out,
  input  logic [1:0] ctrl_strobe,
  output logic [1:0] ctrl_data
);

  localparam int unsigned NBTN  = 16;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reset asserts asynchronously and releases two clk_cpu edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_cpu or negedge rst_cpun) begin
    if (!rst_cpun) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Two-flop synchronizer on all raw buttons, port 2 in the upper byte.
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_s1;
  logic [NBTN-1:0] btn_s2;
  logic [NBTN-1:0] btn_deb;
  logic [NBTN-1:0] btn_eff;

  assign btn_raw = {btn_p2, btn_p1};

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // Per-button debounce: value follows only after DEBOUNCE_CYCLES consecutive differing cycles.
  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb;

    always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        deb <= 1'b0;
      end else if (btn_s2[g] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
        deb <= btn_s2[g];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign btn_deb[g] = deb;
  end

`ifdef JOYPAD_TURBO_EN
  localparam int unsigned FRM_W = $clog2(TURBO_FRAMES + 1);
  localparam logic [FRM_W-1:0] FRM_TOP = FRM_W'(TURBO_FRAMES);

  logic             vblank_q;
  logic             vblank_rise;
  logic             turbo_phase;
  logic [FRM_W-1:0] frame_cnt;
  logic [FRM_W-1:0] frame_nxt;
  logic [NBTN-1:0]  turbo_mask;

  assign vblank_rise = vblank & ~vblank_q;
  assign frame_nxt   = frame_cnt + FRM_W'(1);

  // Phase flips every TURBO_FRAMES vblank rising edges.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q    <= 1'b0;
      frame_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (vblank_rise) begin
        if (frame_nxt == FRM_TOP) begin
          frame_cnt   <= '0;
          turbo_phase <= ~turbo_phase;
        end else begin
          frame_cnt <= frame_nxt;
        end
      end
    end
  end

  // Turbo bits map onto B/A of each port: {p2B,p2A,p1B,p1A}.
  assign turbo_mask = {6'b000000, turbo[3:2], 6'b000000, turbo[1:0]};
  assign btn_eff    = btn_deb & ~(turbo_mask & {NBTN{~turbo_phase}});
`else
  logic unused_turbo;
  assign unused_turbo = ^{turbo, vblank, TURBO_FRAMES[0]};
  assign btn_eff      = btn_deb;
`endif

  // Shift registers: reload wins over strobe; shifting fills with 1s from the top.
  logic [7:0] sr_p1;
  logic [7:0] sr_p2;

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      sr_p1 <= 8'h00;
      sr_p2 <= 8'h00;
    end else if (ctrl_out) begin
      sr_p1 <= btn_eff[7:0];
      sr_p2 <= btn_eff[15:8];
    end else begin
      if (ctrl_strobe[0]) sr_p1 <= {1'b1, sr_p1[7:1]};
      if (ctrl_strobe[1]) sr_p2 <= {1'b1, sr_p2[7:1]};
    end
  end

  assign ctrl_data = {sr_p2[0] & pad_present[1], sr_p1[0] & pad_present[0]};

endmodule

// File: tb/tb_nes_joypad.sv
// Directed table-driven bench for nes_joypad with DEBOUNCE_CYCLES=4, TURBO_FRAMES=2.
module tb_nes_joypad;

  logic       clk_cpu;
  logic       rst_cpun;
  logic [7:0] btn_p1;
  logic [7:0] btn_p2;
  logic [1:0] pad_present;
  logic [3:0] turbo;
  logic       vblank;
  logic       ctrl_out;
  logic [1:0] ctrl_strobe;
  logic [1:0] ctrl_data;

  int tests_run;
  int tests_failed;

  nes_joypad #(
    .DEBOUNCE_CYCLES(4),
    .TURBO_FRAMES   (2)
  ) dut (
    .clk_cpu    (clk_cpu),
    .rst_cpun   (rst_cpun),
    .btn_p1     (btn_p1),
    .btn_p2     (btn_p2),
    .pad_present(pad_present),
    .turbo      (turbo),
    .vblank     (vblank),
    .ctrl_out   (ctrl_out),
    .ctrl_strobe(ctrl_strobe),
    .ctrl_data  (ctrl_data)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] pad;
    logic [1:0] mask;
    logic [8:0] e0;
    logic [8:0] e1;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic latch();
    ctrl_out = 1'b1;
    tick();
    ctrl_out = 1'b0;
  endtask

  // Nine reads: sample the current bit, then strobe the selected ports.
  task automatic read_seq(input logic [1:0] mask, output logic [8:0] r0, output logic [8:0] r1);
    for (int k = 0; k < 9; k++) begin
      r0[k] = ctrl_data[0];
      r1[k] = ctrl_data[1];
      ctrl_strobe = mask;
      tick();
      ctrl_strobe = 2'b00;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] r0;
    logic [8:0] r1;
    logic [5:0] turbo_exp;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{p1: 8'h01, p2: 8'h01, pad: 2'b11, mask: 2'b01, e0: 9'h101, e1: 9'h1FF};
    vecs[1] = '{p1: 8'h81, p2: 8'h10, pad: 2'b11, mask: 2'b11, e0: 9'h181, e1: 9'h110};
    vecs[2] = '{p1: 8'hFF, p2: 8'h5A, pad: 2'b01, mask: 2'b11, e0: 9'h1FF, e1: 9'h000};
    vecs[3] = '{p1: 8'hA5, p2: 8'h3C, pad: 2'b10, mask: 2'b11, e0: 9'h000, e1: 9'h13C};
    vecs[4] = '{p1: 8'h00, p2: 8'hFF, pad: 2'b11, mask: 2'b10, e0: 9'h000, e1: 9'h1FF};

    rst_cpun    = 1'b0;
    btn_p1      = 8'h00;
    btn_p2      = 8'h00;
    pad_present = 2'b11;
    turbo       = 4'b0000;
    vblank      = 1'b0;
    ctrl_out    = 1'b0;
    ctrl_strobe = 2'b00;
    ticks(3);
    check("reset_ctrl_data", 9'(ctrl_data), 9'h000);
    rst_cpun = 1'b1;
    ticks(4);

    for (int v = 0; v < 5; v++) begin
      btn_p1      = vecs[v].p1;
      btn_p2      = vecs[v].p2;
      pad_present = vecs[v].pad;
      ticks(12);
      latch();
      read_seq(vecs[v].mask, r0, r1);
      check($sformatf("vec%0d_port0", v), r0, vecs[v].e0);
      check($sformatf("vec%0d_port1", v), r1, vecs[v].e1);
    end

    // Three-cycle glitch must not reach the debounced value.
    btn_p1 = 8'h00;
    btn_p2 = 8'h00;
    pad_present = 2'b11;
    ticks(12);
    btn_p1 = 8'h01;
    ticks(3);
    btn_p1 = 8'h00;
    ticks(12);
    latch();
    read_seq(2'b01, r0, r1);
    check("glitch_port0", r0, 9'h100);

    // Strobe during ctrl_out=1 must not shift; absent pad 2 reads 0.
    btn_p1      = 8'h01;
    btn_p2      = 8'hFF;
    pad_present = 2'b01;
    ticks(12);
    ctrl_out    = 1'b1;
    ctrl_strobe = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("strobe_while_out%0d", i), 9'(ctrl_data), 9'h001);
    end
    ctrl_out    = 1'b0;
    ctrl_strobe = 2'b00;
    read_seq(2'b11, r0, r1);
    check("after_out_port0", r0, 9'h101);
    check("after_out_port1", r1, 9'h000);

    // Button changes with ctrl_out=0 do not disturb the latched value.
    btn_p1      = 8'hFF;
    pad_present = 2'b11;
    ticks(12);
    latch();
    btn_p1 = 8'h00;
    ticks(12);
    read_seq(2'b01, r0, r1);
    check("hold_port0", r0, 9'h1FF);

    // Asynchronous reset mid-read clears output without a clock edge.
    btn_p1 = 8'hFF;
    ticks(12);
    latch();
    ctrl_strobe = 2'b01;
    ticks(2);
    ctrl_strobe = 2'b00;
    check("midread_before_reset", 9'(ctrl_data[0]), 9'h001);
    #3;
    rst_cpun = 1'b0;
    #1;
    check("midread_async_reset", 9'(ctrl_data), 9'h000);
    tick();
    rst_cpun = 1'b1;
    ticks(4);
    check("post_reset_no_reload", 9'(ctrl_data), 9'h000);
    ticks(12);
    latch();
    check("post_reset_reload", 9'(ctrl_data[0]), 9'h001);

    // Turbo on p1 A across six frames.
    btn_p1 = 8'h01;
    turbo  = 4'b0001;
    ticks(12);
`ifdef JOYPAD_TURBO_EN
    turbo_exp = 6'b001100;
`else
    turbo_exp = 6'b111111;
`endif
    for (int f = 0; f < 6; f++) begin
      latch();
      check($sformatf("turbo_frame%0d", f), 9'(ctrl_data[0]), 9'(turbo_exp[f]));
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
